cam_mem_writer: RTL
===================

Name: cam_mem_writer

Overview:
Camera-side write stage directly upstream of the cellular RAM interface's camera port. It packs a synchronous 8-bit pixel byte stream into 16-bit words and buffers them in a small FIFO. It then drives the memory interface's camera inputs (CMEMADDR, CMEMDOUT, CMEMnWE_asrt, CMEMnWE_deas), which write one frame into a linear region starting at a programmable base address. Control and status connect to the CAMCTRL bus bank.

Parameters:
FIFO_DEPTH, 16, word FIFO entries; power of 2, minimum 4
FRAME_WORDS, 76800, words per frame (320x240 RGB565)
SETUP_CYCLES, 1, cycles address/data are stable before nWE assert pulse (>=1)
WE_LOW_CYCLES, 4, cycles between assert and deassert pulses (>=1; 80 ns at 50 MHz)
HOLD_CYCLES, 1, cycles address/data are held after deassert pulse (>=1)

Ports:
CLK  in  1  system clock (50 MHz domain)
RST  in  1  reset; asynchronous, active-low
CAP_EN  in  1  capture enable, from CAMCTRL register
BASE_ADDR  in  23  word address of frame start; sampled at FRAME_START
FRAME_START  in  1  one-cycle pulse at camera VSYNC, already synchronous to CLK
PIX_VALID  in  1  PIX_DATA valid this cycle; never on consecutive cycles
PIX_DATA  in  8  pixel byte
CMEMADDR  out  23  memory word address
CMEMDOUT  out  16  write data
CMEMnWE_asrt  out  1  one-cycle request to drive MEMnWE low
CMEMnWE_deas  out  1  one-cycle request to release MEMnWE
BUSY  out  1  frame active, or FIFO not empty, or write FSM not IDLE
FRAME_DONE  out  1  one-cycle pulse after last word of a completed frame is written
OVERFLOW  out  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset (RST=0, async): all outputs 0. FSM goes to IDLE, FIFO empties, byte phase = 0, word count = 0, capture inactive.
- Arming: FRAME_START with CAP_EN=1 starts a capture. It latches BASE_ADDR, clears word count, byte phase and OVERFLOW, and sets capture active. FRAME_START with CAP_EN=0 is ignored.
- Packing: applies while capture is active and PIX_VALID=1.
  - Phase 0: the byte is stored as the high byte [15:8].
  - Phase 1: the byte forms the low byte [7:0], and the word is pushed to the FIFO.
  - Byte phase toggles on each valid byte.
  - Bytes are ignored when capture is inactive.
- Word count: increments on each word accepted, whether pushed or dropped. When it reaches FRAME_WORDS, capture goes inactive and later bytes are ignored.
- Full FIFO: a push to a full FIFO drops that word and sets OVERFLOW. A push and a pop in the same cycle on a full FIFO succeed.
- Write FSM:
  - IDLE: if the FIFO is non-empty, pop the word, load CMEMDOUT, and go to SETUP.
  - SETUP: lasts SETUP_CYCLES cycles.
  - ASRT: one cycle with CMEMnWE_asrt=1.
  - LOW: lasts WE_LOW_CYCLES cycles.
  - DEAS: one cycle with CMEMnWE_deas=1.
  - HOLD: lasts HOLD_CYCLES cycles, then the address increments and the FSM returns to IDLE.
  - Defaults give 9 cycles per word, so sustained rate is one byte per 4.5 cycles.
- Outputs during writes: CMEMADDR and CMEMDOUT stay constant from SETUP through HOLD. CMEMADDR = latched base + words written, modulo 2^23; 0x7FFFFF wraps to 0x000000.
- FRAME_DONE: pulses for one cycle on the HOLD-exit cycle of word FRAME_WORDS-1, unless the frame was aborted.
- Abort by CAP_EN: CAP_EN dropping during an active capture makes capture inactive. Words already in the FIFO still drain, and FRAME_DONE is suppressed for that frame.
- FRAME_START during an active or draining frame:
  - A write cycle in progress runs to HOLD exit; an assert is never left without its deassert.
  - The FIFO is then flushed, and the new capture arms (if CAP_EN=1) from the following cycle.
  - Bytes arriving between the pulse and arming are discarded.
  - The old frame gets no FRAME_DONE.
- Mid-operation reset: a reset during LOW emits no CMEMnWE_deas. The memory interface's own reset releases MEMnWE.

Test Plan:
- Reset, then CAP_EN=1, BASE_ADDR=0x000100, FRAME_START, bytes 0x12,0x34,0x56,0x78 spaced 5 cycles -> writes 0x1234@0x000100 and 0x5678@0x000101. Assert pulse comes SETUP_CYCLES after pop, deassert 5 cycles after assert, BUSY falls after last HOLD.
- FRAME_WORDS=4 override, 10 bytes -> exactly 4 writes, FRAME_DONE one pulse at last HOLD exit, bytes 9-10 ignored.
- Bytes every 2 cycles for 100 words, FIFO_DEPTH=4 -> OVERFLOW=1, word count still reaches 100, and fewer than 100 writes occur. OVERFLOW clears at next armed FRAME_START.
- BASE_ADDR=0x7FFFFE, 3 words -> addresses 0x7FFFFE, 0x7FFFFF, 0x000000.
- FRAME_START while in LOW with 3 words queued -> CMEMnWE_deas still issued, remaining 3 words never written, new frame writes from the new BASE_ADDR.
- CAP_EN drops after 2 of 4 words -> 2 writes complete, no FRAME_DONE. Assert RST=0 mid-LOW -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/cam_mem_writer_if.sv
// Camera-port write bus between cam_mem_writer and the cellular RAM interface.
// The writer drives address, data and the one-cycle nWE assert/deassert requests.
interface cam_mem_writer_if;
    logic [22:0] CMEMADDR;
    logic [15:0] CMEMDOUT;
    logic        CMEMnWE_asrt;
    logic        CMEMnWE_deas;

    modport master (output CMEMADDR, CMEMDOUT, CMEMnWE_asrt, CMEMnWE_deas);
    modport slave  (input  CMEMADDR, CMEMDOUT, CMEMnWE_asrt, CMEMnWE_deas);
endinterface

// File: rtl/cam_mem_writer.sv
// Packs camera bytes into 16-bit words, queues them in a small FIFO and writes one
// frame linearly into cellular RAM through the camera port's nWE pulse requests.
//
// state | meaning
// IDLE  | waiting for a queued word; restart/flush happens here
// SETUP | address/data stable before the nWE assert request
// ASRT  | one-cycle CMEMnWE_asrt
// LOW   | nWE held low
// DEAS  | one-cycle CMEMnWE_deas
// HOLD  | address/data held after release, then address advances
module cam_mem_writer #(
    parameter int FIFO_DEPTH    = 16,
    parameter int FRAME_WORDS   = 76800,
    parameter int SETUP_CYCLES  = 1,
    parameter int WE_LOW_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CAP_EN,
    input  logic [22:0]      BASE_ADDR,
    input  logic             FRAME_START,
    input  logic             PIX_VALID,
    input  logic [7:0]       PIX_DATA,
    cam_mem_writer_if.master cmem,
    output logic             BUSY,
    output logic             FRAME_DONE,
    output logic             OVERFLOW
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FRAME_WORDS + 1);
    localparam int SL   = (SETUP_CYCLES > WE_LOW_CYCLES) ? SETUP_CYCLES : WE_LOW_CYCLES;
    localparam int TMAX = (SL > HOLD_CYCLES) ? SL : HOLD_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ASRT  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_DEAS  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]    state;
    logic [TW-1:0] tmr;
    logic [16:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic [7:0]    hi_byte;
    logic          phase;
    logic [CW-1:0] word_cnt;
    logic          active;
    logic          aborted;
    logic          pending;
    logic [22:0]   pend_base;
    logic [22:0]   addr;
    logic [15:0]   dout;
    logic          last_cur;

    logic        idle, fs_arm, arm_now, take, push_req, full, empty, pop, push_ok;
    logic        last_word, hold_exit;
    logic [22:0] arm_base;

    assign idle      = (state == S_IDLE);
    assign fs_arm    = FRAME_START & CAP_EN;
    // A restart waits for the write in flight to leave HOLD, then flushes and arms.
    assign arm_now   = idle & (fs_arm | pending);
    assign arm_base  = fs_arm ? BASE_ADDR : pend_base;
    assign take      = active & CAP_EN & PIX_VALID & ~fs_arm;
    assign push_req  = take & phase;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign pop       = idle & ~empty & ~fs_arm & ~pending;
    assign push_ok   = push_req & (~full | pop);
    assign last_word = (word_cnt == CW'(FRAME_WORDS - 1));
    assign hold_exit = (state == S_HOLD) && (tmr == '0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            active    <= 1'b0;
            aborted   <= 1'b0;
            pending   <= 1'b0;
            pend_base <= '0;
            phase     <= 1'b0;
            hi_byte   <= '0;
            word_cnt  <= '0;
            OVERFLOW  <= 1'b0;
        end else if (arm_now) begin
            active    <= 1'b1;
            aborted   <= 1'b0;
            pending   <= 1'b0;
            phase     <= 1'b0;
            word_cnt  <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            if (fs_arm) begin
                pending   <= 1'b1;
                pend_base <= BASE_ADDR;
                active    <= 1'b0;
                aborted   <= 1'b1;
            end else if (active && !CAP_EN) begin
                active  <= 1'b0;
                aborted <= 1'b1;
            end
            if (take) begin
                phase <= ~phase;
                if (!phase) begin
                    hi_byte <= PIX_DATA;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    if (last_word) active <= 1'b0;
                    if (!push_ok) OVERFLOW <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (arm_now) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (!push_ok && pop) count <= count - 1'b1;
        end
    end

    // Each entry carries a flag marking the frame's final word.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= {last_word, hi_byte, PIX_DATA};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            tmr      <= '0;
            addr     <= '0;
            dout     <= '0;
            last_cur <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_now) begin
                        addr <= arm_base;
                    end else if (pop) begin
                        dout     <= mem[rd_ptr][15:0];
                        last_cur <= mem[rd_ptr][16];
                        tmr      <= TW'(SETUP_CYCLES - 1);
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: if (tmr == '0) state <= S_ASRT; else tmr <= tmr - 1'b1;
                S_ASRT: begin
                    tmr   <= TW'(WE_LOW_CYCLES - 1);
                    state <= S_LOW;
                end
                S_LOW: if (tmr == '0) state <= S_DEAS; else tmr <= tmr - 1'b1;
                S_DEAS: begin
                    tmr   <= TW'(HOLD_CYCLES - 1);
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    if (tmr == '0) begin
                        addr  <= addr + 1'b1;
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign cmem.CMEMADDR     = addr;
    assign cmem.CMEMDOUT     = dout;
    assign cmem.CMEMnWE_asrt = (state == S_ASRT);
    assign cmem.CMEMnWE_deas = (state == S_DEAS);
    assign FRAME_DONE        = hold_exit & last_cur & ~aborted & ~fs_arm;
    assign BUSY              = active | ~empty | ~idle | pending;
endmodule
